pll_reset_sequencer: RTL and testbench

Bring-up sequencer sitting directly upstream of the 50 MHz → 12.5 MHz PLL wrapper on the 50 MHz reference clock. It drives the PLL `rst` input and consumes its `locked` output, synchronising and debouncing lock. It releases a system reset only after lock has been continuously stable. On lock-acquisition timeout it retries, and on lock loss it restarts the PLL.

---
 rtl/pll_rstseq_pkg.sv | 18 +
 rtl/sync_2ff.sv | 25 ++
 rtl/pll_reset_sequencer.sv | 175 +++++++++++++++++
 tb/tb_pll_reset_sequencer.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_rstseq_pkg.sv
// rtl/pll_rstseq_pkg.sv - state encoding and sizing helper for the PLL reset sequencer
//   Exports rstseq_state_t (RESET_PLL, WAIT_LOCK, STABLE, RUN, FAIL) and
//   cnt_width(), which gives the counter width for a cycle count (minimum 1 bit).
package pll_rstseq_pkg;

    typedef enum logic [2:0] {
        RESET_PLL = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAIL      = 3'd4
    } rstseq_state_t;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - single-bit two-flop synchroniser, async active-low reset to 0
//   clk   in  destination clock
//   rst_n in  asynchronous active-low reset
//   d     in  asynchronous input bit
//   q     out synchronised bit, two clk edges of latency
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_reset_sequencer.sv
// rtl/pll_reset_sequencer.sv - PLL reset pulse, lock debounce and system reset release
//   clk        in   50 MHz reference clock (also the PLL refclk)
//   rst_n      in   asynchronous active-low reset
//   pll_locked in   PLL lock indication, asynchronous to clk
//   pll_rst    out  PLL reset, active high
//   sys_rst_n  out  system reset, active low, released only in RUN
//   ready      out  high in RUN
//   fail       out  high in FAIL
//   retry_cnt  out  lock-timeout retries taken in the current sequence
//   Macro PLL_RSTSEQ_TIMEOUT_EN enables the lock timeout, retries and FAIL state;
//   without it the sequencer waits for lock indefinitely and fail/retry_cnt read 0.
module pll_reset_sequencer
    import pll_rstseq_pkg::*;
#(
    parameter int PLL_RST_CYCLES      = 16,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 50000,
    parameter int MAX_RETRIES         = 7
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pll_locked,
    output logic       pll_rst,
    output logic       sys_rst_n,
    output logic       ready,
    output logic       fail,
    output logic [3:0] retry_cnt
);

    if (PLL_RST_CYCLES < 1) begin : g_chk_rst_cycles
        $error("PLL_RST_CYCLES must be at least 1");
    end
    if (LOCK_STABLE_CYCLES < 1) begin : g_chk_stable_cycles
        $error("LOCK_STABLE_CYCLES must be at least 1");
    end
    if (LOCK_TIMEOUT_CYCLES < 1) begin : g_chk_timeout_cycles
        $error("LOCK_TIMEOUT_CYCLES must be at least 1");
    end
    if (MAX_RETRIES > 15 || MAX_RETRIES < 0) begin : g_chk_retries
        $error("MAX_RETRIES must be in 0..15");
    end

    localparam int PW = cnt_width(PLL_RST_CYCLES);
    localparam int SW = cnt_width(LOCK_STABLE_CYCLES);
    localparam logic [PW-1:0] PULSE_LAST  = PW'(PLL_RST_CYCLES - 1);
    localparam logic [SW-1:0] STABLE_LAST = SW'(LOCK_STABLE_CYCLES - 1);

    rstseq_state_t state_q, state_d;
    logic [PW-1:0] pulse_cnt_q, pulse_cnt_d;
    logic [SW-1:0] stable_cnt_q, stable_cnt_d;
    logic          lk_s;

    sync_2ff u_lock_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (pll_locked),
        .q     (lk_s)
    );

`ifdef PLL_RSTSEQ_TIMEOUT_EN
    localparam int TW = cnt_width(LOCK_TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TMO_LAST  = TW'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [3:0]    RETRY_MAX = 4'(MAX_RETRIES);

    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic [3:0]    retry_q, retry_d;
    logic          fail_q;
    logic          timeout_hit;

    function automatic logic is_waiting(input rstseq_state_t s);
        return (s == WAIT_LOCK) || (s == STABLE);
    endfunction

    assign timeout_hit = is_waiting(state_q) && (tmo_cnt_q == TMO_LAST);
`endif

    always_comb begin
        state_d = state_q;
`ifdef PLL_RSTSEQ_TIMEOUT_EN
        retry_d = retry_q;
`endif
        case (state_q)
            RESET_PLL: if (pulse_cnt_q == PULSE_LAST) state_d = WAIT_LOCK;
            WAIT_LOCK: if (lk_s) state_d = STABLE;
            STABLE: begin
                // A dropout only restarts the debounce; the PLL is left running.
                if (!lk_s) begin
                    state_d = WAIT_LOCK;
                end else if (stable_cnt_q == STABLE_LAST) begin
                    state_d = RUN;
                end
            end
            RUN:       if (!lk_s) state_d = RESET_PLL;
            FAIL:      state_d = FAIL;
            default:   state_d = RESET_PLL;
        endcase
`ifdef PLL_RSTSEQ_TIMEOUT_EN
        // Timeout overrides the decode above, including a STABLE->RUN on the same edge.
        if (timeout_hit) begin
            if (retry_q == RETRY_MAX) begin
                state_d = FAIL;
            end else begin
                state_d = RESET_PLL;
                retry_d = retry_q + 4'd1;
            end
        end
        // Lock loss after a successful bring-up starts a fresh retry budget.
        if ((state_q == RUN) && !lk_s) begin
            retry_d = 4'd0;
        end
`endif
    end

    // Each counter runs only while its state is held, so it is zero on every entry.
    always_comb begin
        pulse_cnt_d  = '0;
        stable_cnt_d = '0;
        if ((state_q == RESET_PLL) && (state_d == RESET_PLL)) begin
            pulse_cnt_d = pulse_cnt_q + PW'(1);
        end
        if ((state_q == STABLE) && (state_d == STABLE)) begin
            stable_cnt_d = stable_cnt_q + SW'(1);
        end
    end

`ifdef PLL_RSTSEQ_TIMEOUT_EN
    // Spans WAIT_LOCK and STABLE together so lock glitches cannot extend the budget.
    always_comb begin
        tmo_cnt_d = '0;
        if (is_waiting(state_q) && is_waiting(state_d)) begin
            tmo_cnt_d = tmo_cnt_q + TW'(1);
        end
    end
`endif

    // Outputs are registered from state_d so they track state_q without a lag cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= RESET_PLL;
            pulse_cnt_q  <= '0;
            stable_cnt_q <= '0;
            pll_rst      <= 1'b1;
            sys_rst_n    <= 1'b0;
            ready        <= 1'b0;
        end else begin
            state_q      <= state_d;
            pulse_cnt_q  <= pulse_cnt_d;
            stable_cnt_q <= stable_cnt_d;
            pll_rst      <= (state_d == RESET_PLL) || (state_d == FAIL);
            sys_rst_n    <= (state_d == RUN);
            ready        <= (state_d == RUN);
        end
    end

`ifdef PLL_RSTSEQ_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_q <= '0;
            retry_q   <= 4'd0;
            fail_q    <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            retry_q   <= retry_d;
            fail_q    <= (state_d == FAIL);
        end
    end

    assign fail      = fail_q;
    assign retry_cnt = retry_q;
`else
    assign fail      = 1'b0;
    assign retry_cnt = 4'd0;
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb/tb_pll_reset_sequencer.sv - self-checking bench for pll_reset_sequencer
module tb_pll_reset_sequencer;

    localparam int P    = 4;
    localparam int L    = 8;
    localparam int T    = 64;
    localparam int R    = 2;
    localparam int NMAX = 1100;

    logic       clk        = 1'b0;
    logic       rst_n      = 1'b1;
    logic       pll_locked = 1'b0;
    logic       pll_rst;
    logic       sys_rst_n;
    logic       ready;
    logic       fail;
    logic [3:0] retry_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    // Expected post-edge values, indexed by rising-edge number after rst_n release.
    logic       lk_arr    [NMAX];
    logic       exp_prst  [NMAX];
    logic       exp_sys   [NMAX];
    logic       exp_fail  [NMAX];
    logic [3:0] exp_retry [NMAX];

    pll_reset_sequencer #(
        .PLL_RST_CYCLES      (P),
        .LOCK_STABLE_CYCLES  (L),
        .LOCK_TIMEOUT_CYCLES (T),
        .MAX_RETRIES         (R)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pll_locked (pll_locked),
        .pll_rst    (pll_rst),
        .sys_rst_n  (sys_rst_n),
        .ready      (ready),
        .fail       (fail),
        .retry_cnt  (retry_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int e, input logic [3:0] obs, input logic [3:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s at edge %0d: got %0h, want %0h", tag, e, obs, exp);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_pll_rst"},   -1, {3'b0, pll_rst},   4'd1);
        chk({tag, "_sys_rst_n"}, -1, {3'b0, sys_rst_n}, 4'd0);
        chk({tag, "_ready"},     -1, {3'b0, ready},     4'd0);
        chk({tag, "_fail"},      -1, {3'b0, fail},      4'd0);
        chk({tag, "_retry_cnt"}, -1, retry_cnt,         4'd0);
    endtask

    task automatic clear_model();
        for (int e = 0; e < NMAX; e++) begin
            lk_arr[e]    = 1'b0;
            exp_prst[e]  = 1'b0;
            exp_sys[e]   = 1'b0;
            exp_fail[e]  = 1'b0;
            exp_retry[e] = 4'd0;
        end
    endtask

    task automatic pulse(input int s);
        for (int e = s; e < s + P; e++) if (e >= 0 && e < NMAX) exp_prst[e] = 1'b1;
    endtask

    task automatic hold_lock(input int from, input int to);
        for (int e = from; e <= to && e < NMAX; e++) lk_arr[e] = 1'b1;
    endtask

    task automatic sys_level(input int from, input logic v);
        for (int e = from; e < NMAX; e++) exp_sys[e] = v;
    endtask

    task automatic retry_from(input int from, input logic [3:0] v);
        for (int e = from; e < NMAX; e++) exp_retry[e] = v;
    endtask

    task automatic fail_from(input int from);
        for (int e = from; e < NMAX; e++) begin
            exp_fail[e] = 1'b1;
            exp_prst[e] = 1'b1;
        end
    endtask

    // Lock held from sample edge m; waiting starts after edge wl.  Release comes L edges
    // after STABLE entry, which is two edges after the first lock sample but no earlier
    // than the edge after waiting starts.  A release that would land on or after the
    // attempt's timeout edge loses to the timeout and one retry is modelled.
    task automatic plan_attempt(input int m, input int wl_in, output int rel);
        int wl;
        wl  = wl_in;
        rel = ((m + 2 > wl + 1) ? m + 2 : wl + 1) + L;
`ifdef PLL_RSTSEQ_TIMEOUT_EN
        if (rel >= wl + T) begin
            retry_from(wl + T, 4'd1);
            pulse(wl + T);
            wl  = wl + T + P;
            rel = ((m + 2 > wl + 1) ? m + 2 : wl + 1) + L;
        end
`endif
        sys_level(rel, 1'b1);
    endtask

    task automatic do_reset(input logic lock_level, input string tag);
        rst_n      = 1'b0;
        pll_locked = lock_level;
        #1;
        chk_reset({tag, "_async"});
        repeat (2) @(posedge clk);
        #1;
        chk_reset({tag, "_held"});
        rst_n = 1'b1;
    endtask

    task automatic run(input int n, input string tag);
        for (int e = 0; e < n; e++) begin
            pll_locked = lk_arr[e];
            @(posedge clk);
            #1;
            chk({tag, "_pll_rst"},   e, {3'b0, pll_rst},   {3'b0, exp_prst[e]});
            chk({tag, "_sys_rst_n"}, e, {3'b0, sys_rst_n}, {3'b0, exp_sys[e]});
            chk({tag, "_ready"},     e, {3'b0, ready},     {3'b0, exp_sys[e]});
            chk({tag, "_fail"},      e, {3'b0, fail},      {3'b0, exp_fail[e]});
            chk({tag, "_retry_cnt"}, e, retry_cnt,         exp_retry[e]);
        end
    endtask

    initial begin
        int k, rel, rel2, j, m, st, s, g, n, t;
        #2;

        // Nominal bring-up: fixed lock edge 20 first, then random lock edges.
        for (int it = 0; it < 4; it++) begin
            k = (it == 0) ? 20 : int'($urandom_range(30, 0));
            clear_model();
            pulse(-1);
            hold_lock(k, NMAX - 1);
            plan_attempt(k, P - 1, rel);
            do_reset(1'b0, "nom_rst");
            run(rel + 6, "nominal");
        end

        // One-cycle lock dropout while debouncing.
        for (int it = 0; it < 3; it++) begin
            k  = int'($urandom_range(15, 2));
            s  = (it == 0) ? 5 : int'($urandom_range(L - 2, 0));
            st = (k + 2 > P) ? k + 2 : P;
            g  = st + s;
            clear_model();
            pulse(-1);
            hold_lock(k, g - 1);
            hold_lock(g + 1, NMAX - 1);
            plan_attempt(g + 1, P - 1, rel);
            do_reset(1'b0, "glitch_rst");
            run(rel + 4, "glitch");
        end

        // Lock loss in RUN, PLL restart, relock.
        for (int it = 0; it < 3; it++) begin
            k = int'($urandom_range(20, 0));
            clear_model();
            pulse(-1);
            hold_lock(k, NMAX - 1);
            plan_attempt(k, P - 1, rel);
            j = rel + int'($urandom_range(10, 2));
            m = j + int'($urandom_range(12, 1));
            for (int e = j; e < m; e++) lk_arr[e] = 1'b0;
            sys_level(j + 2, 1'b0);
            pulse(j + 2);
            plan_attempt(m, j + 2 + P, rel2);
            do_reset(1'b0, "loss_rst");
            run(rel2 + 4, "lock_loss");
        end

        // Reset asserted mid-STABLE, then a full sequence with lock already present.
        for (int it = 0; it < 2; it++) begin
            k  = int'($urandom_range(10, 0));
            st = (k + 2 > P) ? k + 2 : P;
            n  = st + 1 + int'($urandom_range(L - 2, 0));
            clear_model();
            pulse(-1);
            hold_lock(k, NMAX - 1);
            plan_attempt(k, P - 1, rel);
            do_reset(1'b0, "pre_stable_rst");
            run(n, "to_stable");
            clear_model();
            pulse(-1);
            hold_lock(0, NMAX - 1);
            plan_attempt(0, P - 1, rel);
            do_reset(1'b1, "mid_stable_rst");
            run(rel + 4, "after_reset");
        end

`ifdef PLL_RSTSEQ_TIMEOUT_EN
        // Never locks: initial pulse, two retries, then FAIL with the PLL parked.
        clear_model();
        s = -1;
        for (int a = 0; a <= R; a++) begin
            pulse(s);
            t = s + P + T;
            if (a < R) begin
                retry_from(t, 4'(a + 1));
                s = t;
            end else begin
                fail_from(t);
            end
        end
        do_reset(1'b0, "nolock_rst");
        run(t + 20, "never_locks");

        // Release edge one before the timeout wins; landing on it loses to the timeout.
        for (int mm = 56; mm <= 57; mm++) begin
            clear_model();
            pulse(-1);
            hold_lock(mm, NMAX - 1);
            plan_attempt(mm, P - 1, rel);
            do_reset(1'b0, "tmo_edge_rst");
            run(rel + 4, "timeout_edge");
        end
`else
        // No timeout: a permanently unlocked PLL just waits.
        clear_model();
        pulse(-1);
        do_reset(1'b0, "nolock_rst");
        run(1000, "waits_forever");

        // Late locks, past where a timeout would otherwise have fired.
        for (int it = 0; it < 2; it++) begin
            m = (it == 0) ? 57 : int'($urandom_range(300, 100));
            clear_model();
            pulse(-1);
            hold_lock(m, NMAX - 1);
            plan_attempt(m, P - 1, rel);
            do_reset(1'b0, "late_rst");
            run(rel + 4, "late_lock");
        end
`endif

        do_reset(1'b0, "final_rst");
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
